// File: rtl/status_handler.sv
// Purpose : ALU status handler; latches flags and raises precise exceptions (div-zero, overflow, address) to the control unit.
// Latency : an exception on SH_valid in cycle N gives SH_trap/SH_busy in N+1; flags update one edge after a clean SH_valid.
// Backpressure: SH_busy stays high from the trap until SH_ack is accepted; SH_valid is ignored while busy.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   SH_status[7:0]             {zero, overflow, carry, negative, invalid_address, div_zero, 2'b00}
//   SH_valid, SH_pc            completing instruction and its PC
//   SH_check_ovf, SH_mem_access qualify overflow / invalid_address as trap-worthy
//   SH_ack                     control unit has taken the trap
//   SH_cnt_clr                 synchronous clear of the exception counter
//   SH_flags, SH_trap, SH_busy, SH_cause, SH_epc, SH_vector, SH_exc_count  (all registered except SH_vector)
module status_handler #(
  parameter logic [31:0] TRAP_VECTOR = 32'h8000_0180,
  parameter int          COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             SH_status,
  input  logic                   SH_valid,
  input  logic                   SH_check_ovf,
  input  logic                   SH_mem_access,
  input  logic [31:0]            SH_pc,
  input  logic                   SH_ack,
  input  logic                   SH_cnt_clr,
  output logic [3:0]             SH_flags,
  output logic                   SH_trap,
  output logic                   SH_busy,
  output logic [1:0]             SH_cause,
  output logic [31:0]            SH_epc,
  output logic [31:0]            SH_vector,
  output logic [COUNT_WIDTH-1:0] SH_exc_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TRAP     = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

  state_t      state;
  state_t      state_nxt;

  logic        div_zero;
  logic        ovf_trap;
  logic        addr_trap;
  logic        exc;
  logic        take_exc;
  logic        ack_taken;
  logic [1:0]  cause_nxt;
  logic        unused_status;

  // Low status bits carry no information.
  assign unused_status = ^SH_status[1:0];

  assign div_zero  = SH_status[2];
  assign ovf_trap  = SH_status[6] & SH_check_ovf;
  assign addr_trap = SH_status[3] & SH_mem_access;
  assign exc       = SH_valid & (div_zero | ovf_trap | addr_trap);

  // Only the highest-priority cause is recorded.
  always_comb begin
    cause_nxt = 2'd0;
    if (div_zero)       cause_nxt = 2'd1;
    else if (ovf_trap)  cause_nxt = 2'd2;
    else if (addr_trap) cause_nxt = 2'd3;
  end

  assign take_exc  = (state == IDLE) & exc;
  assign ack_taken = (state == WAIT_ACK) & SH_ack;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (exc) state_nxt = TRAP;
      TRAP:     state_nxt = WAIT_ACK;
      WAIT_ACK: if (SH_ack) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the state register only, so no input reaches them combinationally.
  always_comb begin
    SH_trap = (state == TRAP);
    SH_busy = (state != IDLE);
  end

  assign SH_vector = TRAP_VECTOR;

  // Flags only follow clean instructions completing while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      SH_flags <= 4'd0;
    end else if ((state == IDLE) && SH_valid && !exc) begin
      SH_flags <= SH_status[7:4];
    end
  end

  // Cause is cleared when the trap is acknowledged; EPC stays for post-mortem reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      SH_cause <= 2'd0;
      SH_epc   <= 32'd0;
    end else if (take_exc) begin
      SH_cause <= cause_nxt;
      SH_epc   <= SH_pc;
    end else if (ack_taken) begin
      SH_cause <= 2'd0;
    end
  end

  // Saturating exception counter; clear beats a simultaneous increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      SH_exc_count <= '0;
    end else if (SH_cnt_clr) begin
      SH_exc_count <= '0;
    end else if (take_exc && (SH_exc_count != COUNT_MAX)) begin
      SH_exc_count <= SH_exc_count + COUNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_status_handler.sv
module tb_status_handler;

  logic        clk;
  logic        rst_n;
  logic [7:0]  SH_status;
  logic        SH_valid;
  logic        SH_check_ovf;
  logic        SH_mem_access;
  logic [31:0] SH_pc;
  logic        SH_ack;
  logic        SH_cnt_clr;
  logic [3:0]  SH_flags;
  logic        SH_trap;
  logic        SH_busy;
  logic [1:0]  SH_cause;
  logic [31:0] SH_epc;
  logic [31:0] SH_vector;
  logic [7:0]  SH_exc_count;

  int checks = 0;
  int errors = 0;

  // Reference model: "waiting" means a trap is outstanding; "fresh" means it was raised on the last edge.
  bit          m_waiting;
  bit          m_fresh;
  int          m_flags;
  int          m_cause;
  logic [31:0] m_epc;
  int          m_count;
  int          trap_seen;

  status_handler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .SH_status    (SH_status),
    .SH_valid     (SH_valid),
    .SH_check_ovf (SH_check_ovf),
    .SH_mem_access(SH_mem_access),
    .SH_pc        (SH_pc),
    .SH_ack       (SH_ack),
    .SH_cnt_clr   (SH_cnt_clr),
    .SH_flags     (SH_flags),
    .SH_trap      (SH_trap),
    .SH_busy      (SH_busy),
    .SH_cause     (SH_cause),
    .SH_epc       (SH_epc),
    .SH_vector    (SH_vector),
    .SH_exc_count (SH_exc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_waiting = 0; m_fresh = 0; m_flags = 0; m_cause = 0; m_epc = 32'd0; m_count = 0;
  endtask

  // One rising edge of the specification's rules, using the inputs held before the edge.
  task automatic model_edge();
    bit d0, ov, ad;
    if (!rst_n) begin
      model_reset();
      return;
    end
    d0 = SH_status[2];
    ov = SH_status[6] && SH_check_ovf;
    ad = SH_status[3] && SH_mem_access;
    if (!m_waiting) begin
      if (SH_valid && (d0 || ov || ad)) begin
        m_cause   = d0 ? 1 : (ov ? 2 : 3);
        m_epc     = SH_pc;
        m_waiting = 1;
        m_fresh   = 1;
        if (m_count < 255) m_count = m_count + 1;
      end else if (SH_valid) begin
        m_flags = SH_status[7:4];
      end
    end else if (m_fresh) begin
      m_fresh = 0;
    end else if (SH_ack) begin
      m_waiting = 0;
      m_cause   = 0;
    end
    if (SH_cnt_clr) m_count = 0;
  endtask

  task automatic compare_all();
    check_val("flags",  {28'd0, SH_flags}, m_flags);
    check_val("trap",   {31'd0, SH_trap},  {31'd0, m_fresh});
    check_val("busy",   {31'd0, SH_busy},  {31'd0, m_waiting});
    check_val("cause",  {30'd0, SH_cause}, m_cause);
    check_val("epc",    SH_epc,            m_epc);
    check_val("count",  {24'd0, SH_exc_count}, m_count);
    check_val("vector", SH_vector,         32'h8000_0180);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    if (SH_trap) trap_seen++;
    compare_all();
  endtask

  task automatic idle_inputs();
    SH_status = 8'd0; SH_valid = 0; SH_check_ovf = 0; SH_mem_access = 0;
    SH_pc = 32'd0; SH_ack = 0; SH_cnt_clr = 0;
  endtask

  task automatic drive(input logic [7:0] st, input bit ovf, input bit mem, input logic [31:0] pc);
    SH_status = st; SH_valid = 1; SH_check_ovf = ovf; SH_mem_access = mem; SH_pc = pc;
  endtask

  // Raise a div-zero exception and acknowledge it: 3 cycles.
  task automatic exc_and_ack(input logic [31:0] pc);
    drive(8'b0000_0100, 0, 0, pc); tick();
    idle_inputs(); tick();
    SH_ack = 1; tick();
    SH_ack = 0;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    trap_seen = 0;
    rst_n = 1'b0;
    #12;
    compare_all();
    rst_n = 1'b1;
    tick();

    // Clean instruction loads flags, no trap.
    drive(8'b1000_0000, 0, 0, 32'h100); tick();
    check_val("flags_zero", {28'd0, SH_flags}, 32'h8);
    idle_inputs(); tick(); tick();
    check_val("no_trap_clean", trap_seen, 0);
    check_val("count_clean", {24'd0, SH_exc_count}, 0);

    // V + div_zero: div_zero wins.
    drive(8'b0100_0100, 1, 0, 32'h0040_0010); tick();
    check_val("trap_dz", {31'd0, SH_trap}, 1);
    check_val("cause_dz", {30'd0, SH_cause}, 1);
    check_val("epc_dz", SH_epc, 32'h0040_0010);
    check_val("busy_dz", {31'd0, SH_busy}, 1);
    check_val("flags_held", {28'd0, SH_flags}, 32'h8);
    idle_inputs(); tick();
    check_val("trap_one_cycle", {31'd0, SH_trap}, 0);
    SH_ack = 1; tick(); SH_ack = 0;

    // Invalid address: only trap-worthy with mem_access.
    drive(8'b0000_1000, 0, 0, 32'h200); tick();
    check_val("addr_nomem_trap", {31'd0, SH_trap}, 0);
    check_val("addr_nomem_flags", {28'd0, SH_flags}, 0);
    drive(8'b0000_1000, 0, 1, 32'h204); tick();
    check_val("addr_cause", {30'd0, SH_cause}, 3);
    idle_inputs(); tick(); SH_ack = 1; tick(); SH_ack = 0;

    // Hammer SH_valid while waiting for ack; count must move by one only.
    SH_cnt_clr = 1; tick(); SH_cnt_clr = 0;
    trap_seen = 0;
    drive(8'b0000_0100, 0, 0, 32'h300);
    for (int i = 0; i < 6; i++) tick();
    SH_ack = 1; tick(); SH_ack = 0;
    check_val("hammer_busy", {31'd0, SH_busy}, 0);
    check_val("hammer_cause", {30'd0, SH_cause}, 0);
    check_val("hammer_count", {24'd0, SH_exc_count}, 1);
    check_val("hammer_traps", trap_seen, 1);
    idle_inputs(); tick();

    // Saturation, then clear beats a simultaneous increment.
    for (int i = 0; i < 260; i++) exc_and_ack(32'h1000 + i);
    check_val("count_sat", {24'd0, SH_exc_count}, 255);
    drive(8'b0000_0100, 0, 0, 32'h2000); SH_cnt_clr = 1; tick();
    check_val("clr_wins", {24'd0, SH_exc_count}, 0);
    check_val("clr_trap", {31'd0, SH_trap}, 1);
    idle_inputs(); tick(); SH_ack = 1; tick(); SH_ack = 0;

    // Asynchronous reset during WAIT_ACK.
    drive(8'b0100_0000, 1, 0, 32'h3000); tick();
    idle_inputs(); tick(); tick();
    check_val("pre_rst_busy", {31'd0, SH_busy}, 1);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    tick();
    #2 rst_n = 1'b1;
    trap_seen = 0;
    for (int i = 0; i < 4; i++) tick();
    check_val("rst_no_trap", trap_seen, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      SH_status     = 8'($urandom);
      SH_valid      = ($urandom_range(0, 3) != 0);
      SH_check_ovf  = $urandom_range(0, 1);
      SH_mem_access = $urandom_range(0, 1);
      SH_pc         = $urandom;
      SH_ack        = ($urandom_range(0, 2) == 0);
      SH_cnt_clr    = ($urandom_range(0, 63) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/status_handler.md
STATUS_HANDLER -- requirements
Module: status_handler

Interface
REQ-001 Parameter TRAP_VECTOR, default 32'h8000_0180, exception handler address driven on SH_vector.
REQ-002 Parameter COUNT_WIDTH, default 8, width of the exception counter.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SH_status  input  8  ALU status byte, bit order {zero, overflow, carry, negative, invalid_address, div_zero, 2'b00}; bits [1:0] ignored.
REQ-006 SH_valid  input  1  SH_status/SH_pc belong to an instruction completing this cycle.
REQ-007 SH_check_ovf  input  1  instruction is signed add/sub; overflow is trap-worthy.
REQ-008 SH_mem_access  input  1  ALU result is a word address; invalid_address is trap-worthy.
REQ-009 SH_pc  input  32  PC of the completing instruction.
REQ-010 SH_ack  input  1  control unit has taken the trap.
REQ-011 SH_cnt_clr  input  1  synchronous clear of SH_exc_count.
REQ-012 SH_flags  output  4  registered {Z,V,C,N} of last non-excepting instruction.
REQ-013 SH_trap  output  1  one-cycle trap request pulse.
REQ-014 SH_busy  output  1  high while not IDLE; upstream stalls.
REQ-015 SH_cause  output  2  0 none, 1 div_zero, 2 overflow, 3 address error.
REQ-016 SH_epc  output  32  PC of the excepting instruction.
REQ-017 SH_vector  output  32  constant TRAP_VECTOR.
REQ-018 SH_exc_count  output  COUNT_WIDTH  saturating count of exceptions taken.

Function
REQ-019 Exception condition: div_zero, or (overflow and SH_check_ovf), or (invalid_address and SH_mem_access), qualified by SH_valid.
REQ-020 Cause priority: div_zero > overflow > address error; only the highest is recorded.
REQ-021 FSM states IDLE, TRAP, WAIT_ACK; encoding free.
REQ-022 IDLE: SH_valid with exception -> capture SH_cause, SH_epc on that edge, go TRAP; SH_valid without exception -> load SH_flags from status bits [7:4], stay IDLE.
REQ-023 SH_flags not updated by an excepting instruction nor outside IDLE.
REQ-024 TRAP: SH_trap=1 for exactly this one cycle; unconditionally go WAIT_ACK next edge.
REQ-025 WAIT_ACK: hold SH_cause/SH_epc; SH_ack=1 -> go IDLE, SH_cause cleared to 0 on same edge; SH_epc retained.
REQ-026 SH_ack outside WAIT_ACK ignored.
REQ-027 SH_busy = (state != IDLE), decoded from state register.
REQ-028 SH_valid ignored in TRAP/WAIT_ACK, including the cycle SH_ack is accepted; no flags, cause or count change.
REQ-029 Latency: exception on SH_valid in cycle N -> SH_trap and SH_busy high in N+1; earliest next accepted SH_valid in cycle following ack edge.
REQ-030 SH_exc_count increments by 1 on each IDLE->TRAP transition; saturates at all-ones, no wrap.
REQ-031 SH_cnt_clr clears count; clr wins over simultaneous increment.
REQ-032 No combinational path from inputs to any output except SH_vector (constant).

Reset
REQ-033 rst_n low asynchronously forces state IDLE, SH_flags=0, SH_trap=0, SH_busy=0, SH_cause=0, SH_epc=0, SH_exc_count=0.
REQ-034 Reset asserted in TRAP or WAIT_ACK abandons the trap; no SH_trap pulse after release.
REQ-035 First edge after rst_n rises behaves as IDLE.

Verification
REQ-036 Bench: SH_valid, SH_status=8'b1000_0000, checks low -> SH_flags=4'b1000 next cycle, SH_trap never high, count 0.
REQ-037 Bench: SH_valid, SH_status=8'b0100_0100 (V+div_zero), SH_check_ovf=1, SH_pc=32'h0040_0010 -> next cycle SH_trap=1 one cycle, SH_cause=1, SH_epc=32'h0040_0010, SH_busy=1, count 1, SH_flags unchanged.
REQ-038 Bench: SH_status=8'b0000_1000 with SH_mem_access=0 -> no trap, flags 0; with SH_mem_access=1 -> SH_cause=3.
REQ-039 Bench: in WAIT_ACK drive SH_valid with div_zero each cycle, SH_ack after 5 cycles -> single trap, count 1, SH_cause 0 and SH_busy 0 after ack edge.
REQ-040 Bench: 260 back-to-back acked exceptions -> SH_exc_count=255; then SH_cnt_clr together with new exception -> count 0.
REQ-041 Bench: rst_n pulsed low mid-clock during WAIT_ACK -> all outputs 0 immediately, no SH_trap after release.
